// File: rtl/inst_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
interface inst_decode_stage_if #(
   parameter int INST_W = 9,
   parameter int CNT_W  = 16
);
   logic              Start;
   logic [INST_W-1:0] InstIn;
   logic              InstValid;
   logic              InstReady;
   logic              Flush;
   logic              OutValid;
   logic              OutReady;
   logic [3:0]        OpOut;
   logic              CmpMode;
   logic [1:0]        RegA;
   logic [1:0]        RegB;
   logic [4:0]        Imm;
   logic              RegWrite;
   logic              MemRead;
   logic              MemWrite;
   logic              Branch;
   logic              Halted;
   logic              Done;
   logic [CNT_W-1:0]  DecodeCount;

   modport slave (
      input  Start, InstIn, InstValid, Flush, OutReady,
      output InstReady, OutValid, OpOut, CmpMode, RegA, RegB, Imm,
             RegWrite, MemRead, MemWrite, Branch, Halted, Done, DecodeCount
   );

   modport master (
      output Start, InstIn, InstValid, Flush, OutReady,
      input  InstReady, OutValid, OpOut, CmpMode, RegA, RegB, Imm,
             RegWrite, MemRead, MemWrite, Branch, Halted, Done, DecodeCount
   );
endinterface

// File: rtl/inst_decode_stage.sv
// Decode stage with run/halt control and a 2-entry output skid FIFO.
// Optional macro DECODE_STATS_EN builds the saturating popped-instruction counter.
module inst_decode_stage #(
   parameter int INST_W = 9,
   parameter int CNT_W  = 16
) (
   input logic                 Clk,
   input logic                 Reset_n,
   inst_decode_stage_if.slave  bus
);

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB = 4'h1, OP_LSH = 4'h2, OP_RSH = 4'h3,
      OP_XOR = 4'h4, OP_AND = 4'h5, OP_ORR = 4'h6, OP_PAR = 4'h7,
      OP_BEQ = 4'h8, OP_BNE = 4'h9, OP_BLT = 4'hA, OP_BRK = 4'hB,
      OP_STR = 4'hC, OP_LOD = 4'hD, OP_TGB = 4'hE, OP_ASR = 4'hF
   } op_mne_e;

   typedef enum logic { RTYPE = 1'b0, CMP = 1'b1 } op_cmp_mne_e;
   typedef enum logic { HALT = 1'b0, RUN = 1'b1 } state_e;

   typedef struct packed {
      op_mne_e     op;
      op_cmp_mne_e cmp;
      logic [1:0]  rega;
      logic [1:0]  regb;
      logic [4:0]  imm;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
   } dec_t;

   function automatic dec_t f_decode(input logic [INST_W-1:0] inst);
      dec_t d;
      d.op   = op_mne_e'(inst[8:5]);
      d.cmp  = RTYPE;
      d.rega = inst[4:3];
      d.regb = inst[2:1];
      d.imm  = inst[4:0];
      d.rw   = 1'b0;
      d.mr   = 1'b0;
      d.mw   = 1'b0;
      d.br   = 1'b0;
      case (d.op)
         OP_ADD, OP_SUB, OP_LSH, OP_RSH, OP_XOR, OP_AND,
         OP_ORR, OP_PAR, OP_TGB, OP_ASR: d.rw = 1'b1;
         OP_LOD: begin
            d.rw = 1'b1;
            d.mr = 1'b1;
         end
         OP_STR: d.mw = 1'b1;
         OP_BEQ, OP_BNE, OP_BLT: begin
            d.br  = 1'b1;
            d.cmp = CMP;
         end
         default: ;
      endcase
      return d;
   endfunction

   state_e     r_state;
   dec_t       r_fifo [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       r_done;

   logic w_accept;
   logic w_pop;
   dec_t w_head;

   assign bus.InstReady = (r_state == RUN) && (r_count < 2'd2) && !bus.Flush;
   assign bus.OutValid  = (r_count != 2'd0);
   assign w_accept      = bus.InstValid && bus.InstReady;
   assign w_pop         = bus.OutValid && bus.OutReady;
   assign w_head        = r_fifo[r_rd_ptr];

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state   <= HALT;
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
         r_done    <= 1'b0;
      end else begin
         if (r_state == HALT && bus.Start)
            r_state <= RUN;
         else if (w_accept && op_mne_e'(bus.InstIn[8:5]) == OP_BRK)
            r_state <= HALT;

         // Flush beats both accept and pop; a pop in that cycle is discarded
         if (bus.Flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_done   <= 1'b0;
         end else begin
            if (w_accept) begin
               r_fifo[r_wr_ptr] <= f_decode(bus.InstIn);
               r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
               r_rd_ptr <= ~r_rd_ptr;
            case ({w_accept, w_pop})
               2'b10:   r_count <= r_count + 2'd1;
               2'b01:   r_count <= r_count - 2'd1;
               default: r_count <= r_count;
            endcase
            r_done <= w_pop && (w_head.op == OP_BRK);
         end
      end
   end

   assign bus.OpOut    = w_head.op;
   assign bus.CmpMode  = w_head.cmp;
   assign bus.RegA     = w_head.rega;
   assign bus.RegB     = w_head.regb;
   assign bus.Imm      = w_head.imm;
   assign bus.RegWrite = w_head.rw;
   assign bus.MemRead  = w_head.mr;
   assign bus.MemWrite = w_head.mw;
   assign bus.Branch   = w_head.br;
   assign bus.Halted   = (r_state == HALT);
   assign bus.Done     = r_done;

`ifdef DECODE_STATS_EN
   logic [CNT_W-1:0] r_dec_cnt;

   always_ff @(posedge Clk) begin
      if (!Reset_n)
         r_dec_cnt <= '0;
      else if (r_state == HALT && bus.Start)
         r_dec_cnt <= '0;
      else if (w_pop && !bus.Flush && r_dec_cnt != {CNT_W{1'b1}})
         r_dec_cnt <= r_dec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign bus.DecodeCount = r_dec_cnt;
`else
   assign bus.DecodeCount = '0;
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
// Table-driven bench for inst_decode_stage with a queue scoreboard on popped entries.
module tb_inst_decode_stage;

   typedef struct packed {
      logic [3:0] op;
      logic       cmp;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [4:0] imm;
      logic       rw;
      logic       mr;
      logic       mw;
      logic       br;
   } exp_t;

   typedef struct packed {
      logic [8:0] inst;
      exp_t       exp;
   } vec_t;

   logic Clk;
   logic Reset_n;
   int   n_chk;
   int   n_fail;
   int   exp_cnt;
   exp_t cur_exp;
   exp_t sbq[$];
   vec_t tbl[10];
   vec_t brk_v;

   inst_decode_stage_if #(.INST_W(9), .CNT_W(16)) bus ();

   inst_decode_stage #(.INST_W(9), .CNT_W(16)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic vec_t mk(input logic [3:0] op, input logic [4:0] lo,
                               input logic cmp, input logic [1:0] ra, input logic [1:0] rb,
                               input logic rw, input logic mr, input logic mw, input logic br);
      vec_t v;
      v.inst = {op, lo};
      v.exp  = '{op: op, cmp: cmp, ra: ra, rb: rb, imm: lo, rw: rw, mr: mr, mw: mw, br: br};
      return v;
   endfunction

   function automatic exp_t got();
      return '{op: bus.OpOut, cmp: bus.CmpMode, ra: bus.RegA, rb: bus.RegB, imm: bus.Imm,
               rw: bus.RegWrite, mr: bus.MemRead, mw: bus.MemWrite, br: bus.Branch};
   endfunction

   function automatic int exp_dc();
`ifdef DECODE_STATS_EN
      return exp_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      if (!Reset_n) begin
         sbq.delete();
         exp_cnt = 0;
      end else if (bus.Flush) begin
         sbq.delete();
         if (bus.Start && bus.Halted) exp_cnt = 0;
      end else begin
         if (bus.Start && bus.Halted) exp_cnt = 0;
         if (bus.OutValid && bus.OutReady) begin
            if (sbq.size() == 0) begin
               chk("pop_underflow", 32'd1, 32'd0);
            end else begin
               chk("pop_fields", 32'(got()), 32'(sbq.pop_front()));
               if (exp_cnt != 32'hFFFF) exp_cnt++;
            end
         end
         if (bus.InstValid && bus.InstReady) sbq.push_back(cur_exp);
      end
   end

   initial begin
      n_chk = 0; n_fail = 0; exp_cnt = 0;
      Reset_n = 1'b0;
      bus.Start = 1'b0; bus.InstIn = '0; bus.InstValid = 1'b0;
      bus.Flush = 1'b0; bus.OutReady = 1'b0;
      cur_exp = '0;

      //        op     low5      cmp   ra     rb     rw mr mw br
      tbl[0] = mk(4'h0, 5'b01100, 1'b0, 2'd1, 2'd2, 1, 0, 0, 0); // ADD
      tbl[1] = mk(4'h1, 5'b11011, 1'b0, 2'd3, 2'd1, 1, 0, 0, 0); // SUB
      tbl[2] = mk(4'h8, 5'b10110, 1'b1, 2'd2, 2'd3, 0, 0, 0, 1); // BEQ
      tbl[3] = mk(4'hC, 5'b00101, 1'b0, 2'd0, 2'd2, 0, 0, 1, 0); // STR
      tbl[4] = mk(4'hD, 5'b01010, 1'b0, 2'd1, 2'd1, 1, 1, 0, 0); // LOD
      tbl[5] = mk(4'h9, 5'b11111, 1'b1, 2'd3, 2'd3, 0, 0, 0, 1); // BNE
      tbl[6] = mk(4'hA, 5'b00000, 1'b1, 2'd0, 2'd0, 0, 0, 0, 1); // BLT
      tbl[7] = mk(4'hE, 5'b10001, 1'b0, 2'd2, 2'd0, 1, 0, 0, 0); // TGB
      tbl[8] = mk(4'h7, 5'b01001, 1'b0, 2'd1, 2'd0, 1, 0, 0, 0); // PAR
      tbl[9] = mk(4'hF, 5'b00110, 1'b0, 2'd0, 2'd3, 1, 0, 0, 0); // ASR
      brk_v  = mk(4'hB, 5'b00000, 1'b0, 2'd0, 2'd0, 0, 0, 0, 0); // BRK

      // Reset state
      repeat (2) tick();
      chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
      chk("rst_instready", 32'(bus.InstReady), 32'd0);
      chk("rst_halted", 32'(bus.Halted), 32'd1);
      chk("rst_done", 32'(bus.Done), 32'd0);
      chk("rst_fields", 32'(got()), 32'd0);
      chk("rst_dcount", 32'(bus.DecodeCount), 32'd0);
      Reset_n = 1'b1;
      tick();
      chk("halt_ready", 32'(bus.InstReady), 32'd0);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      chk("start_halted", 32'(bus.Halted), 32'd0);
      chk("start_ready", 32'(bus.InstReady), 32'd1);

      // Streaming decode of every table entry
      bus.OutReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.InstIn = tbl[i].inst;
         cur_exp = tbl[i].exp;
         bus.InstValid = 1'b1;
         tick();
         if (i == 0) begin
            chk("first_outvalid", 32'(bus.OutValid), 32'd1);
            chk("first_fields", 32'(got()), 32'(tbl[0].exp));
         end
      end
      bus.InstValid = 1'b0;
      repeat (2) tick();
      chk("stream_drained", 32'(bus.OutValid), 32'd0);
      chk("stream_sbq_empty", 32'(sbq.size()), 32'd0);
      chk("stream_dcount", 32'(bus.DecodeCount), 32'(exp_dc()));

      // Fill to 2, third word held until a single pop frees a slot
      bus.OutReady = 1'b0;
      bus.InstValid = 1'b1;
      bus.InstIn = tbl[1].inst; cur_exp = tbl[1].exp; tick();
      bus.InstIn = tbl[2].inst; cur_exp = tbl[2].exp; tick();
      bus.InstIn = tbl[3].inst; cur_exp = tbl[3].exp; tick();
      chk("full_ready", 32'(bus.InstReady), 32'd0);
      chk("full_outvalid", 32'(bus.OutValid), 32'd1);
      tick();
      chk("full_ready_hold", 32'(bus.InstReady), 32'd0);
      bus.OutReady = 1'b1;
      tick();
      bus.OutReady = 1'b0;
      chk("ready_after_pop", 32'(bus.InstReady), 32'd1);
      tick();
      bus.InstValid = 1'b0;
      chk("refull_ready", 32'(bus.InstReady), 32'd0);
      bus.OutReady = 1'b1;
      repeat (3) tick();
      chk("order_sbq_empty", 32'(sbq.size()), 32'd0);
      chk("order_outvalid", 32'(bus.OutValid), 32'd0);

      // BRK halts intake; Done pulses on its pop; Start resumes
      bus.OutReady = 1'b0;
      bus.InstIn = brk_v.inst; cur_exp = brk_v.exp; bus.InstValid = 1'b1;
      tick();
      chk("brk_ready", 32'(bus.InstReady), 32'd0);
      chk("brk_halted", 32'(bus.Halted), 32'd1);
      bus.InstIn = tbl[0].inst; cur_exp = tbl[0].exp;
      repeat (2) tick();
      chk("brk_hold_ready", 32'(bus.InstReady), 32'd0);
      chk("brk_hold_count1", 32'(bus.OutValid), 32'd1);
      bus.OutReady = 1'b1;
      tick();
      chk("brk_done_pulse", 32'(bus.Done), 32'd1);
      chk("brk_halted_after", 32'(bus.Halted), 32'd1);
      tick();
      chk("brk_done_clear", 32'(bus.Done), 32'd0);
      chk("brk_empty", 32'(bus.OutValid), 32'd0);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      chk("resume_ready", 32'(bus.InstReady), 32'd1);
      tick();
      bus.InstValid = 1'b0;
      chk("resume_outvalid", 32'(bus.OutValid), 32'd1);
      tick();
      chk("resume_sbq_empty", 32'(sbq.size()), 32'd0);

      // Flush a full FIFO whose tail is BRK, with a pop requested
      bus.OutReady = 1'b0;
      bus.InstValid = 1'b1;
      bus.InstIn = tbl[4].inst; cur_exp = tbl[4].exp; tick();
      bus.InstIn = brk_v.inst;  cur_exp = brk_v.exp;  tick();
      bus.InstValid = 1'b0;
      chk("pre_flush_halted", 32'(bus.Halted), 32'd1);
      chk("pre_flush_outvalid", 32'(bus.OutValid), 32'd1);
      bus.Flush = 1'b1;
      bus.OutReady = 1'b1;
      tick();
      bus.Flush = 1'b0;
      chk("flush_outvalid", 32'(bus.OutValid), 32'd0);
      chk("flush_done", 32'(bus.Done), 32'd0);
      chk("flush_halted", 32'(bus.Halted), 32'd1);
      chk("flush_dcount", 32'(bus.DecodeCount), 32'(exp_dc()));
      tick();
      chk("flush_done_next", 32'(bus.Done), 32'd0);

      // Reset with two entries buffered in RUN
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      bus.OutReady = 1'b0;
      bus.InstValid = 1'b1;
      bus.InstIn = tbl[5].inst; cur_exp = tbl[5].exp; tick();
      bus.InstIn = tbl[6].inst; cur_exp = tbl[6].exp; tick();
      bus.InstValid = 1'b0;
      chk("prerst_head", 32'(bus.OpOut), 32'h9);
      Reset_n = 1'b0;
      tick();
      chk("rst2_outvalid", 32'(bus.OutValid), 32'd0);
      chk("rst2_halted", 32'(bus.Halted), 32'd1);
      chk("rst2_fields", 32'(got()), 32'd0);
      chk("rst2_dcount", 32'(bus.DecodeCount), 32'd0);
      chk("rst2_ready", 32'(bus.InstReady), 32'd0);
      Reset_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
